branch_flag_unit: RTL
=====================

Name: branch_flag_unit

Overview:
- Consumer end of the ALU interface.
- Captures the ALU status flags (zero, carry, sign, overflow) into a flag register and owns the program counter.
- Resolves conditional and unconditional branches against the current flags, including same-cycle forwarding from the ALU.
- Sits between the ALU outputs and instruction fetch; drives next fetch address, pipeline flush and link-register writeback.

Parameters:
PC_WIDTH, 32, width of program counter and all address ports
RESET_PC, 32'h00000000, pc value after reset
PC_STEP, 4, sequential pc increment in bytes

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  holds pc and branch evaluation when 1
alu_valid  input  1  ALU result/flags valid this cycle
flag_update  input  1  with alu_valid, the op writes flags
zero_flag  input  1  ALU zero flag
carry_flag  input  1  ALU carry flag
sign_flag  input  1  ALU sign flag
overflow_flag  input  1  ALU overflow flag
br_valid  input  1  branch instruction present this cycle
br_cond  input  4  branch condition code
br_target  input  PC_WIDTH  absolute target (immediate branches)
reg_target  input  PC_WIDTH  register-sourced target (br)
pc  output  PC_WIDTH  current fetch address
flags  output  4  registered {Z,C,S,V}
flush  output  1  one-cycle pulse: taken branch, discard fetched instruction
link_we  output  1  one-cycle pulse: write link register
link_data  output  PC_WIDTH  return address for link write
illegal_br  output  1  one-cycle pulse: undefined br_cond

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, flags=4'b0000, flush=0, link_we=0, link_data=0, illegal_br=0. Reset overrides every other input, including mid-branch and mid-stall.
- Flag register:
  - Loads {zero,carry,sign,overflow} on any edge where alu_valid & flag_update, independent of stall.
  - Otherwise holds its value.
- Effective flags for branch evaluation:
  - If alu_valid & flag_update in the same cycle as br_valid, evaluate with the incoming ALU flags (forwarded).
  - Otherwise evaluate with the flags register.
- br_cond encoding:
  - 0000 b (always)
  - 0001 bz (Z=1)
  - 0010 bnz (Z=0)
  - 0011 bcy (C=1)
  - 0100 bncy (C=0)
  - 0101 bs (S=1)
  - 0110 bns (S=0)
  - 0111 bv (V=1)
  - 1000 bnv (V=0)
  - 1001 bl (always, with link)
  - 1010 br (always, target=reg_target)
  - 1011-1111 illegal.
- Registered outputs, edge with stall=0:
  - Taken branch: pc<=target (low 2 bits passed unmodified); flush=1 next cycle.
  - Not-taken or no branch: pc<=pc+PC_STEP, wrapping modulo 2^PC_WIDTH; flush=0.
  - bl: link_we=1 and link_data=pc+PC_STEP (pre-branch pc), both one cycle after.
  - Illegal code: illegal_br=1 for one cycle; treated as not taken, pc+PC_STEP.
- stall=1:
  - pc, flush, link_we and illegal_br do not advance; pulse outputs are 0.
  - br_valid is ignored; the source holds it until stall drops.
- Latency: decision to new pc is 1 cycle. No back-to-back dependency: a branch in the cycle after flush is evaluated normally.

Test Plan:
- rst=1 for 2 cycles -> pc=0, flags=0000, all pulses 0. Release, 3 cycles no branch -> pc=0x4, 0x8, 0xC.
- ALU result 10+20=30 (Z=0,C=0,S=0,V=0, flag_update=1), next cycle bz target 0x40 at pc=0x10 -> not taken, pc=0x14, flush=0. Same with bnz -> pc=0x40, flush pulse.
- Same cycle: ALU 7+0xFFFFFFFF (C=1, Z=0) with flag_update, plus bcy target 0x80 -> forwarded C taken, pc=0x80, flags=0100 next cycle.
- bl target 0x200 at pc=0x1C -> pc=0x200, link_we pulse, link_data=0x20, flush pulse. br with reg_target=0x100 -> pc=0x100.
- br_cond=1111 at pc=0x30 -> illegal_br pulse, pc=0x34. Then stall=1 for 3 cycles with bnv valid -> pc stays 0x34. Stall drop with V=0 -> taken.
- Overflow case 0x7FFFFFFF+0x7FFFFFFF (V=1,S=1) flags latched. Assert rst in the same cycle as taken b -> pc=RESET_PC, no flush. pc=0xFFFFFFFC not taken -> pc=0x0 wrap.

Source files
------------

// File: rtl/branch_flag_unit.sv
// Branch and flag unit: latches ALU status flags, owns the program counter and
// resolves conditional/unconditional branches with same-cycle flag forwarding.
module branch_flag_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}},
    parameter int                  PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                alu_valid,
    input  logic                flag_update,
    input  logic                zero_flag,
    input  logic                carry_flag,
    input  logic                sign_flag,
    input  logic                overflow_flag,
    input  logic                br_valid,
    input  logic [3:0]          br_cond,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic [PC_WIDTH-1:0] reg_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [3:0]          flags,
    output logic                flush,
    output logic                link_we,
    output logic [PC_WIDTH-1:0] link_data,
    output logic                illegal_br
);

    localparam logic [3:0] COND_B    = 4'b0000;
    localparam logic [3:0] COND_BZ   = 4'b0001;
    localparam logic [3:0] COND_BNZ  = 4'b0010;
    localparam logic [3:0] COND_BCY  = 4'b0011;
    localparam logic [3:0] COND_BNCY = 4'b0100;
    localparam logic [3:0] COND_BS   = 4'b0101;
    localparam logic [3:0] COND_BNS  = 4'b0110;
    localparam logic [3:0] COND_BV   = 4'b0111;
    localparam logic [3:0] COND_BNV  = 4'b1000;
    localparam logic [3:0] COND_BL   = 4'b1001;
    localparam logic [3:0] COND_BR   = 4'b1010;

    // Flag vector layout is {Z,C,S,V}.
    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] f);
        logic t;
        case (cond)
            COND_B:    t = 1'b1;
            COND_BZ:   t = f[3];
            COND_BNZ:  t = ~f[3];
            COND_BCY:  t = f[2];
            COND_BNCY: t = ~f[2];
            COND_BS:   t = f[1];
            COND_BNS:  t = ~f[1];
            COND_BV:   t = f[0];
            COND_BNV:  t = ~f[0];
            COND_BL:   t = 1'b1;
            COND_BR:   t = 1'b1;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic cond_legal(input logic [3:0] cond);
        logic l;
        if (cond <= COND_BR) begin
            l = 1'b1;
        end else begin
            l = 1'b0;
        end
        return l;
    endfunction

    logic [PC_WIDTH-1:0] pc_r;
    logic [3:0]          flags_r;
    logic                flush_r;
    logic                link_we_r;
    logic [PC_WIDTH-1:0] link_data_r;
    logic                illegal_r;

    logic [3:0]          alu_flags_s;
    logic                flag_load_s;
    logic [3:0]          eff_flags_s;
    logic [PC_WIDTH-1:0] seq_pc_s;
    logic [PC_WIDTH-1:0] target_s;
    logic                taken_s;
    logic                is_link_s;
    logic                illegal_s;

    // Branch decision from forwarded or registered flags.
    always_comb begin
        alu_flags_s = {zero_flag, carry_flag, sign_flag, overflow_flag};
        flag_load_s = alu_valid & flag_update;
        if (flag_load_s) begin
            eff_flags_s = alu_flags_s;
        end else begin
            eff_flags_s = flags_r;
        end
        if (br_cond == COND_BR) begin
            target_s = reg_target;
        end else begin
            target_s = br_target;
        end
        seq_pc_s  = pc_r + PC_WIDTH'(PC_STEP);
        taken_s   = br_valid & cond_legal(br_cond) & cond_taken(br_cond, eff_flags_s);
        is_link_s = br_valid & (br_cond == COND_BL);
        illegal_s = br_valid & ~cond_legal(br_cond);
    end

    // Flag register: loads on any flag-writing ALU op, stall or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (flag_load_s) begin
            flags_r <= alu_flags_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    // PC and pulse outputs; stall freezes pc and suppresses pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            flush_r     <= 1'b0;
            link_we_r   <= 1'b0;
            link_data_r <= {PC_WIDTH{1'b0}};
            illegal_r   <= 1'b0;
        end else if (stall) begin
            pc_r        <= pc_r;
            flush_r     <= 1'b0;
            link_we_r   <= 1'b0;
            link_data_r <= link_data_r;
            illegal_r   <= 1'b0;
        end else begin
            if (taken_s) begin
                pc_r <= target_s;
            end else begin
                pc_r <= seq_pc_s;
            end
            flush_r   <= taken_s;
            link_we_r <= is_link_s;
            if (is_link_s) begin
                link_data_r <= seq_pc_s;
            end else begin
                link_data_r <= link_data_r;
            end
            illegal_r <= illegal_s;
        end
    end

    assign pc         = pc_r;
    assign flags      = flags_r;
    assign flush      = flush_r;
    assign link_we    = link_we_r;
    assign link_data  = link_data_r;
    assign illegal_br = illegal_r;

endmodule
